// File: rtl/rv32_scoreboard_hazard.sv
// Scoreboard hazard unit: per-register pending counters for variable-latency writes,
// RAW / WAW-saturation / global-full detection and per-stage stall/flush generation.
module rv32_scoreboard_hazard #(
   parameter int REG_BITS        = 5,
   parameter int CNT_BITS        = 2,
   parameter int MAX_OUTSTANDING = 4,
   localparam int OUT_BITS       = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                decode_valid_in,
   input  logic [REG_BITS-1:0] decode_rs1_in,
   input  logic                decode_rs1_read_in,
   input  logic [REG_BITS-1:0] decode_rs2_in,
   input  logic                decode_rs2_read_in,
   input  logic [REG_BITS-1:0] decode_rd_in,
   input  logic                decode_rd_writeback_in,
   input  logic                decode_long_latency_in,
   input  logic                complete_valid_in,
   input  logic [REG_BITS-1:0] complete_rd_in,
   input  logic                mem_busy_in,
   input  logic                mem_branch_taken_in,
   output logic                fetch_stall_out,
   output logic                fetch_flush_out,
   output logic                decode_stall_out,
   output logic                decode_flush_out,
   output logic                execute_stall_out,
   output logic                execute_flush_out,
   output logic                mem_stall_out,
   output logic                mem_flush_out,
   output logic                writeback_flush_out,
   output logic [OUT_BITS-1:0] outstanding_out,
   output logic                full_out,
   output logic                underflow_err_out
);

   localparam int NREG = 1 << REG_BITS;
   localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

   logic [CNT_BITS-1:0] cnt_q [NREG];
   logic [CNT_BITS-1:0] cnt_d [NREG];
   logic [OUT_BITS-1:0] outstanding_q, outstanding_d;
   logic                underflow_q, underflow_d;

   logic branch, ll_write, raw, waw_sat, glob_full, hazard;
   logic issue, comp_nz, comp, same_reg;

   always_comb begin
      branch    = mem_branch_taken_in && !mem_busy_in;
      ll_write  = decode_valid_in && decode_rd_writeback_in && decode_long_latency_in &&
                  (decode_rd_in != '0);
      raw       = decode_valid_in &&
                  ((decode_rs1_read_in && (decode_rs1_in != '0) && (cnt_q[decode_rs1_in] != '0)) ||
                   (decode_rs2_read_in && (decode_rs2_in != '0) && (cnt_q[decode_rs2_in] != '0)));
      waw_sat   = ll_write && (cnt_q[decode_rd_in] == CNT_MAX);
      glob_full = ll_write && full_out;
      hazard    = (raw || waw_sat || glob_full) && !branch;
   end

   assign mem_stall_out       = mem_busy_in;
   assign execute_stall_out   = mem_stall_out;
   assign decode_stall_out    = execute_stall_out || hazard;
   assign fetch_stall_out     = decode_stall_out;
   assign fetch_flush_out     = 1'b0;
   assign decode_flush_out    = branch;
   assign execute_flush_out   = branch || (hazard && !execute_stall_out);
   assign mem_flush_out       = 1'b0;
   assign writeback_flush_out = mem_busy_in;

   assign outstanding_out   = outstanding_q;
   assign full_out          = (outstanding_q == OUT_BITS'(MAX_OUTSTANDING));
   assign underflow_err_out = underflow_q;

   // Issue and completion on the same register cancel, so neither touches the counter.
   always_comb begin
      issue    = ll_write && !decode_stall_out && !branch;
      comp_nz  = complete_valid_in && (complete_rd_in != '0);
      comp     = comp_nz && (cnt_q[complete_rd_in] != '0);
      same_reg = issue && comp && (complete_rd_in == decode_rd_in);
      for (int i = 0; i < NREG; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      if (issue && !same_reg) begin
         cnt_d[decode_rd_in] = cnt_q[decode_rd_in] + CNT_BITS'(1);
      end
      if (comp && !same_reg) begin
         cnt_d[complete_rd_in] = cnt_q[complete_rd_in] - CNT_BITS'(1);
      end
      outstanding_d = outstanding_q;
      if (issue && !comp) begin
         outstanding_d = outstanding_q + OUT_BITS'(1);
      end else if (comp && !issue) begin
         outstanding_d = outstanding_q - OUT_BITS'(1);
      end
      underflow_d = underflow_q || (comp_nz && (cnt_q[complete_rd_in] == '0));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= '0;
         end
         outstanding_q <= '0;
         underflow_q   <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         outstanding_q <= outstanding_d;
         underflow_q   <= underflow_d;
      end
   end

endmodule

// File: tb/tb_rv32_scoreboard_hazard.sv
// Directed bench for rv32_scoreboard_hazard: stimulus pushes expected output vectors,
// a negedge monitor pops and compares them against the DUT.
module tb_rv32_scoreboard_hazard;

   logic       clk = 1'b0;
   logic       reset;
   logic       decode_valid_in;
   logic [4:0] decode_rs1_in;
   logic       decode_rs1_read_in;
   logic [4:0] decode_rs2_in;
   logic       decode_rs2_read_in;
   logic [4:0] decode_rd_in;
   logic       decode_rd_writeback_in;
   logic       decode_long_latency_in;
   logic       complete_valid_in;
   logic [4:0] complete_rd_in;
   logic       mem_busy_in;
   logic       mem_branch_taken_in;
   logic       fetch_stall_out, fetch_flush_out, decode_stall_out, decode_flush_out;
   logic       execute_stall_out, execute_flush_out, mem_stall_out, mem_flush_out;
   logic       writeback_flush_out;
   logic [2:0] outstanding_out;
   logic       full_out;
   logic       underflow_err_out;

   rv32_scoreboard_hazard #(.REG_BITS(5), .CNT_BITS(2), .MAX_OUTSTANDING(4)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .decode_valid_in        (decode_valid_in),
      .decode_rs1_in          (decode_rs1_in),
      .decode_rs1_read_in     (decode_rs1_read_in),
      .decode_rs2_in          (decode_rs2_in),
      .decode_rs2_read_in     (decode_rs2_read_in),
      .decode_rd_in           (decode_rd_in),
      .decode_rd_writeback_in (decode_rd_writeback_in),
      .decode_long_latency_in (decode_long_latency_in),
      .complete_valid_in      (complete_valid_in),
      .complete_rd_in         (complete_rd_in),
      .mem_busy_in            (mem_busy_in),
      .mem_branch_taken_in    (mem_branch_taken_in),
      .fetch_stall_out        (fetch_stall_out),
      .fetch_flush_out        (fetch_flush_out),
      .decode_stall_out       (decode_stall_out),
      .decode_flush_out       (decode_flush_out),
      .execute_stall_out      (execute_stall_out),
      .execute_flush_out      (execute_flush_out),
      .mem_stall_out          (mem_stall_out),
      .mem_flush_out          (mem_flush_out),
      .writeback_flush_out    (writeback_flush_out),
      .outstanding_out        (outstanding_out),
      .full_out               (full_out),
      .underflow_err_out      (underflow_err_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [13:0] v;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   // {fetch_stall, fetch_flush, decode_stall, decode_flush, execute_stall, execute_flush,
   //  mem_stall, mem_flush, writeback_flush, outstanding[2:0], full, underflow}
   function automatic logic [13:0] ev(input logic fs, input logic ds, input logic df,
                                      input logic es, input logic ef, input logic ms,
                                      input logic wf, input logic [2:0] o, input logic f,
                                      input logic u);
      return {fs, 1'b0, ds, df, es, ef, ms, 1'b0, wf, o, f, u};
   endfunction

   wire [13:0] act = {fetch_stall_out, fetch_flush_out, decode_stall_out, decode_flush_out,
                      execute_stall_out, execute_flush_out, mem_stall_out, mem_flush_out,
                      writeback_flush_out, outstanding_out, full_out, underflow_err_out};

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_total++;
         if (act !== e.v) begin
            $display("FAIL %s: got %b expected %b", e.name, act, e.v);
         end else begin
            n_pass++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      decode_valid_in        = 1'b0;
      decode_rs1_in          = '0;
      decode_rs1_read_in     = 1'b0;
      decode_rs2_in          = '0;
      decode_rs2_read_in     = 1'b0;
      decode_rd_in           = '0;
      decode_rd_writeback_in = 1'b0;
      decode_long_latency_in = 1'b0;
      complete_valid_in      = 1'b0;
      complete_rd_in         = '0;
      mem_busy_in            = 1'b0;
      mem_branch_taken_in    = 1'b0;
   endtask

   task automatic dec(input logic [4:0] rs1, input logic r1, input logic [4:0] rs2,
                      input logic r2, input logic [4:0] rd, input logic wb, input logic ll);
      decode_valid_in        = 1'b1;
      decode_rs1_in          = rs1;
      decode_rs1_read_in     = r1;
      decode_rs2_in          = rs2;
      decode_rs2_read_in     = r2;
      decode_rd_in           = rd;
      decode_rd_writeback_in = wb;
      decode_long_latency_in = ll;
   endtask

   task automatic cmp(input logic [4:0] rd);
      complete_valid_in = 1'b1;
      complete_rd_in    = rd;
   endtask

   task automatic chk(input string nm, input logic [13:0] v);
      exp_t e;
      e.name = nm;
      e.v    = v;
      exp_q.push_back(e);
      tick();
   endtask

   localparam logic [13:0] Z0 = 14'b0;

   initial begin
      idle();
      reset = 1'b1;
      tick();
      tick();
      chk("reset_state", Z0);
      reset = 1'b0;

      // load x5 then RAW on x5
      idle(); dec(0, 0, 0, 0, 5, 1, 1);
      chk("issue_x5", ev(0,0,0,0,0,0,0, 3'd0, 0, 0));
      idle(); dec(5, 1, 0, 0, 0, 0, 0);
      chk("raw_x5", ev(1,1,0,0,1,0,0, 3'd1, 0, 0));
      idle(); dec(5, 1, 0, 0, 0, 0, 0); cmp(5);
      chk("raw_during_comp", ev(1,1,0,0,1,0,0, 3'd1, 0, 0));
      idle(); dec(5, 1, 0, 0, 0, 0, 0);
      chk("raw_release", ev(0,0,0,0,0,0,0, 3'd0, 0, 0));

      // x0 never tracked
      idle(); dec(0, 1, 0, 0, 0, 1, 1);
      chk("x0_no_stall", Z0);
      idle();
      chk("x0_no_outstanding", Z0);

      // WAW saturation on x7
      idle(); dec(0, 0, 0, 0, 7, 1, 1);
      chk("waw_issue1", ev(0,0,0,0,0,0,0, 3'd0, 0, 0));
      chk("waw_issue2", ev(0,0,0,0,0,0,0, 3'd1, 0, 0));
      chk("waw_issue3", ev(0,0,0,0,0,0,0, 3'd2, 0, 0));
      cmp(7);
      chk("waw_sat_stall", ev(1,1,0,0,1,0,0, 3'd3, 0, 0));
      idle(); dec(0, 0, 0, 0, 7, 1, 1);
      chk("waw_proceeds", ev(0,0,0,0,0,0,0, 3'd2, 0, 0));
      idle(); cmp(7);
      chk("waw_drain3", ev(0,0,0,0,0,0,0, 3'd3, 0, 0));
      chk("waw_drain2", ev(0,0,0,0,0,0,0, 3'd2, 0, 0));
      chk("waw_drain1", ev(0,0,0,0,0,0,0, 3'd1, 0, 0));
      idle();

      // global outstanding limit
      for (int r = 1; r <= 4; r++) begin
         idle(); dec(0, 0, 0, 0, 5'(r), 1, 1);
         chk("fill", ev(0,0,0,0,0,0,0, 3'(r - 1), 0, 0));
      end
      idle(); dec(0, 0, 0, 0, 10, 1, 1);
      chk("glob_full_stall", ev(1,1,0,0,1,0,0, 3'd4, 1, 0));
      idle(); cmp(4);
      chk("full_no_decode", ev(0,0,0,0,0,0,0, 3'd4, 1, 0));
      idle(); dec(0, 0, 0, 0, 1, 1, 1); cmp(1);
      chk("issue_comp_same", ev(0,0,0,0,0,0,0, 3'd3, 0, 0));
      idle(); dec(1, 1, 0, 0, 0, 0, 0);
      chk("cnt1_unchanged", ev(1,1,0,0,1,0,0, 3'd3, 0, 0));
      idle(); dec(0, 0, 1, 1, 0, 0, 0); cmp(1);
      chk("raw_rs2_x1", ev(1,1,0,0,1,0,0, 3'd3, 0, 0));
      idle(); dec(1, 1, 0, 0, 0, 0, 0);
      chk("x1_released", ev(0,0,0,0,0,0,0, 3'd2, 0, 0));

      // memory busy with pending RAW on x2, branch ignored while busy
      idle(); dec(2, 1, 0, 0, 0, 0, 0); mem_busy_in = 1'b1;
      chk("busy1", ev(1,1,0,1,0,1,1, 3'd2, 0, 0));
      mem_branch_taken_in = 1'b1;
      chk("busy2_branch_ignored", ev(1,1,0,1,0,1,1, 3'd2, 0, 0));
      idle(); dec(2, 1, 0, 0, 8, 1, 1); mem_busy_in = 1'b1; mem_branch_taken_in = 1'b1;
      chk("busy3_branch_ignored", ev(1,1,0,1,0,1,1, 3'd2, 0, 0));
      mem_busy_in = 1'b0;
      chk("branch_suppresses_raw", ev(0,0,1,0,1,0,0, 3'd2, 0, 0));
      idle(); cmp(9);
      chk("no_issue_on_branch", ev(0,0,0,0,0,0,0, 3'd2, 0, 0));

      // sticky underflow, then reset mid-operation
      idle();
      chk("underflow_set", ev(0,0,0,0,0,0,0, 3'd2, 0, 1));
      chk("underflow_sticky", ev(0,0,0,0,0,0,0, 3'd2, 0, 1));
      dec(0, 0, 0, 0, 6, 1, 1); cmp(3); reset = 1'b1;
      chk("pre_reset", ev(0,0,0,0,0,0,0, 3'd2, 0, 1));
      idle(); reset = 1'b0;
      chk("after_reset", Z0);
      dec(2, 1, 6, 1, 0, 0, 0);
      chk("cnt_cleared", Z0);
      idle(); dec(3, 1, 0, 0, 0, 0, 0);
      chk("cnt3_cleared", Z0);
      idle();

      for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
         @(negedge clk);
      end
      #1;
      if (exp_q.size() != 0) begin
         n_total++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
